// File: rtl/expand_burst.sv
// Expands {burst_len, base_addr} descriptors into a per-beat address stream, one beat per cycle.
// Optional macro EXPAND_BURST_BOUNDARY_SPLIT_EN also flags beats that precede a 4 KB crossing.
module expand_burst #(
  parameter int unsigned AddrWidth         = 64,
  parameter int unsigned DataWidthBytesLog = 6,
  parameter int unsigned BurstLenWidth     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BurstLenWidth+AddrWidth-1:0] burst_dout,
  input  logic                               burst_empty_n,
  output logic                               burst_read,
  output logic [AddrWidth:0]                 addr_din,
  input  logic                               addr_full_n,
  output logic                               addr_write
);

  localparam int unsigned HiWidth  = AddrWidth - DataWidthBytesLog;
  localparam int unsigned PageBits = 12 - DataWidthBytesLog;

  localparam logic [HiWidth-1:0]       HiOne  = 1;
  localparam logic [BurstLenWidth-1:0] LenOne = 1;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [HiWidth-1:0]       cur_hi_q, cur_hi_d;
  logic [DataWidthBytesLog-1:0] lo_q, lo_d;
  logic [BurstLenWidth-1:0] remaining_q, remaining_d;

  logic [BurstLenWidth-1:0]     desc_len;
  logic [HiWidth-1:0]           desc_hi;
  logic [DataWidthBytesLog-1:0] desc_lo;
  logic                         rem_zero;
  logic                         last;
  logic                         pop;
  logic                         push;

  assign desc_len = burst_dout[BurstLenWidth+AddrWidth-1 -: BurstLenWidth];
  assign desc_hi  = burst_dout[AddrWidth-1:DataWidthBytesLog];
  assign desc_lo  = burst_dout[DataWidthBytesLog-1:0];
  assign rem_zero = (remaining_q == '0);

`ifdef EXPAND_BURST_BOUNDARY_SPLIT_EN
  // Page-offset bits of the beat all ones: the next beat starts a new 4 KB page.
  assign last = rem_zero | (&cur_hi_q[PageBits-1:0]);
`else
  assign last = rem_zero;
`endif

  always_comb begin
    state_d     = state_q;
    cur_hi_d    = cur_hi_q;
    lo_d        = lo_q;
    remaining_d = remaining_q;
    pop         = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        pop = burst_empty_n;
        if (burst_empty_n) begin
          cur_hi_d    = desc_hi;
          lo_d        = desc_lo;
          remaining_d = desc_len;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        push = addr_full_n;
        if (addr_full_n) begin
          if (!rem_zero) begin
            cur_hi_d    = cur_hi_q + HiOne;
            remaining_d = remaining_q - LenOne;
          end else begin
            // Final beat: chain straight into the next descriptor to avoid a bubble.
            pop = burst_empty_n;
            if (burst_empty_n) begin
              cur_hi_d    = desc_hi;
              lo_d        = desc_lo;
              remaining_d = desc_len;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of FIFO status.
  always_comb begin
    burst_read = pop & rst_n;
    addr_write = push & rst_n;
    addr_din   = rst_n ? {last, cur_hi_q, lo_q} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_hi_q    <= '0;
      lo_q        <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_hi_q    <= cur_hi_d;
      lo_q        <= lo_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: doc/expand_burst.md
# expand_burst

Expands burst descriptors back into a per-beat address stream, reversing the coalescing done by the burst detector on the request side. Each input descriptor `{burst_len, base_addr}` is turned into `burst_len+1` consecutive beat addresses spaced one data word apart. The block sits between the descriptor FIFO and any per-beat consumer, such as a response tracker or a narrow-port replay path. It streams at one beat per cycle with no bubble between descriptors.

## Interface
- `AddrWidth`, 64, byte-address width.
- `DataWidthBytesLog`, 6, log2 of data word size in bytes; beat stride is `1<<DataWidthBytesLog`.
- `BurstLenWidth`, 8, width of the `burst_len` field; a descriptor carries `burst_len+1` beats.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `burst_dout`  in  BurstLenWidth+AddrWidth  descriptor; `burst_len` in the MSBs, `base_addr` in the LSBs.
- `burst_empty_n`  in  1  descriptor FIFO not empty.
- `burst_read`  out  1  descriptor pop, combinational.
- `addr_din`  out  AddrWidth+1  `{last, beat_addr}`.
- `addr_full_n`  in  1  output FIFO not full.
- `addr_write`  out  1  output push, combinational.

## Operation
- State machine has two states, IDLE and EMIT.
- Registers:
  - `state`
  - `cur_hi`, the upper address field, AddrWidth-DataWidthBytesLog bits.
  - `lo`, DataWidthBytesLog bits, latched from `base_addr` and applied unchanged to every beat.
  - `remaining`, BurstLenWidth bits.
- Beat address is `{cur_hi, lo}`.
- `last` is `(remaining == 0)`, optionally widened by the configuration feature below.
- IDLE:
  - `burst_read = burst_empty_n`.
  - On a pop, latch `cur_hi`, `lo` and `remaining = burst_len`, then go to EMIT.
- EMIT:
  - `addr_write = addr_full_n`.
  - On a write with `remaining != 0`: `cur_hi += 1`, `remaining -= 1`.
  - On a write with `remaining == 0`, the final beat:
    - `burst_read = burst_empty_n` in the same cycle.
    - If a pop occurs, load the new descriptor and stay in EMIT.
    - Otherwise go to IDLE.
- `burst_read` is 0 in every other case.
- `cur_hi` increments modulo 2^(AddrWidth-DataWidthBytesLog); wrap-around is silent.
- `burst_len` all-ones produces 2^BurstLenWidth beats with no counter overflow.
- `burst_dout` is sampled only in the cycle where `burst_read = 1`.

## Timing
- Reset (asynchronous assert, synchronous release): `state = IDLE`, `cur_hi = 0`, `lo = 0`, `remaining = 0`.
- While `rst_n = 0`, `burst_read = 0`, `addr_write = 0` and `addr_din = 0`.
- Latency: descriptor popped in cycle t, first beat written in cycle t+1.
- Throughput: one beat per cycle while `addr_full_n = 1`. Back-to-back descriptors produce no idle cycle.
- Backpressure: while `addr_full_n = 0`:
  - `addr_write = 0`.
  - `addr_din` and all state are held.
  - `burst_read = 0` in EMIT.
- Empty descriptor FIFO in IDLE: stay in IDLE with `burst_read = 0`.
- Reset asserted mid-burst: the undelivered beats of the current descriptor are discarded. No partial descriptor is retained after release.
- The same-cycle final-beat write and next-descriptor read is legal and required.

## Configuration
- `EXPAND_BURST_BOUNDARY_SPLIT_EN` defined:
  - `last` is also asserted on any beat where the next beat address would cross a 4 KB boundary.
  - The condition is that beat address bits [11:DataWidthBytesLog] are all ones and `remaining != 0`.
  - Downstream consumers can then segment at 4 KB.
- Not defined: `last` is asserted only on the final beat of each descriptor.
- Addresses and beat counts are identical either way.

## Test plan
All scenarios use the defaults, so the beat stride is 0x40.
1. Descriptor `{3, 0x1000}` with `addr_full_n = 1` -> writes 0x1000, 0x1040, 0x1080 and 0x10C0 on the 4 cycles after the pop; `last = 1` only on 0x10C0.
2. Descriptors `{0, 0x2000}` and `{1, 0x3000}` queued together -> 3 consecutive writes 0x2000 (last), 0x3000 and 0x3040 (last). The second pop coincides with the 0x2000 write.
3. Descriptor `{2, 0x4000}`, with `addr_full_n = 0` for 2 cycles after the first beat -> no write for 2 cycles, `addr_din` held at 0x4040, then 0x4040 and 0x4080 are written with no skip or duplicate.
4. Descriptor `{1, 0x5004}` -> writes 0x5004 and 0x5044; the low bits are preserved on both beats.
5. Descriptor `{1, 0x0FC0}` -> writes 0x0FC0 and 0x1000. With the macro, 0x0FC0 has `last = 1`; without it, `last = 0`. Beat 0x1000 has `last = 1` in both cases.
6. Descriptor `{7, 0x6000}` with reset pulsed after the 3rd beat -> writes stop at once. After release the FIFO next holds `{0, 0x7000}`, which yields a single write 0x7000 (last) one cycle after its pop.
